// File: rtl/uop_pkg.sv
// Shared uop, queue-window and dispatch types for the front end.
package uop_pkg;

    localparam int unsigned INSTR_Q_DEPTH = 16;
    localparam int unsigned INSTR_Q_WIDTH = 4;
    localparam int unsigned ISSUE_WIDTH   = 4;
    localparam int unsigned OPC_W         = 8;
    localparam int unsigned PC_W          = 16;
    localparam int unsigned Q_IDX_W       = (INSTR_Q_WIDTH > 1) ? $clog2(INSTR_Q_WIDTH) : 1;
    localparam int unsigned ISSUE_IDX_W   = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    typedef struct packed {
        logic             serialize;
        logic [OPC_W-1:0] opcode;
        logic [PC_W-1:0]  pc;
    } uop_t;

    typedef uop_t [INSTR_Q_WIDTH-1:0] instr_queue_t;
    typedef uop_t [ISSUE_WIDTH-1:0]   dispatch_bundle_t;

    typedef enum logic [0:0] {
        RUN         = 1'b0,
        SERIAL_WAIT = 1'b1
    } dispatch_state_e;

endpackage

// File: rtl/dispatch_count_calc.sv
// How many head uops may leave this cycle: min(avail, ISSUE_WIDTH) cut short
// at the first serializing uop, which must travel alone.
module dispatch_count_calc #(
    parameter int unsigned Q_DEPTH     = uop_pkg::INSTR_Q_DEPTH,
    parameter int unsigned ISSUE_WIDTH = uop_pkg::ISSUE_WIDTH,
    localparam int unsigned AVAIL_W    = $clog2(Q_DEPTH + 1),
    localparam int unsigned CNT_W      = $clog2(ISSUE_WIDTH + 1)
) (
    input  uop_pkg::instr_queue_t head,
    input  logic [AVAIL_W-1:0]    avail,
    output logic [CNT_W-1:0]      n_c,
    output logic                  serial_head_c
);
    import uop_pkg::*;

    logic [CNT_W-1:0] lim;

    always_comb begin
        lim = (avail > AVAIL_W'(ISSUE_WIDTH)) ? CNT_W'(ISSUE_WIDTH) : CNT_W'(avail);
        n_c = lim;
        // Descending scan leaves the lowest serializing slot as the cut point
        for (int i = ISSUE_WIDTH - 1; i >= 1; i--) begin
            if ((CNT_W'(i) < lim) && head[Q_IDX_W'(i)].serialize) begin
                n_c = CNT_W'(i);
            end
        end
        if (head[0].serialize && (lim != '0)) begin
            n_c = CNT_W'(1);
        end
        serial_head_c = head[0].serialize;
    end

endmodule

// File: rtl/instr_queue_dispatcher.sv
// Pops uops from the instruction queue head into a registered issue bundle,
// holding on backpressure, draining the ROB around serializing uops and flushing.
module instr_queue_dispatcher #(
    parameter int unsigned Q_DEPTH     = uop_pkg::INSTR_Q_DEPTH,
    parameter int unsigned Q_WIDTH     = uop_pkg::INSTR_Q_WIDTH,
    parameter int unsigned ISSUE_WIDTH = uop_pkg::ISSUE_WIDTH,
    localparam int unsigned SIZE_W     = $clog2(Q_DEPTH),
    localparam int unsigned DEQ_W      = $clog2(Q_WIDTH + 1),
    localparam int unsigned CNT_W      = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush_in,
    input  uop_pkg::instr_queue_t     q_head_in,
    input  logic [SIZE_W-1:0]         q_size_in,
    input  logic                      q_full_in,
    input  logic                      q_empty_in,
    output logic [DEQ_W-1:0]          deq_out,
    output logic                      issue_valid_out,
    output logic [CNT_W-1:0]          issue_count_out,
    output uop_pkg::dispatch_bundle_t issue_bundle_out,
    input  logic                      issue_ready_in,
    input  logic                      rob_empty_in
);
    import uop_pkg::*;

    localparam int unsigned AVAIL_W = $clog2(Q_DEPTH + 1);

    dispatch_state_e  state_q, state_d;
    logic             valid_d;
    logic [CNT_W-1:0] count_d;
    dispatch_bundle_t bundle_d;
    logic [AVAIL_W-1:0] avail;
    logic [CNT_W-1:0] n;
    logic             ser0;
    logic             load_ok;

    // A full queue reports a wrapped size of zero, so full overrides it
    assign avail = q_full_in  ? AVAIL_W'(Q_DEPTH) :
                   q_empty_in ? '0 : AVAIL_W'(q_size_in);

    dispatch_count_calc #(
        .Q_DEPTH     (Q_DEPTH),
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_count_calc (
        .head          (q_head_in),
        .avail         (avail),
        .n_c           (n),
        .serial_head_c (ser0)
    );

    assign load_ok = !flush_in && (state_q == RUN) && (!issue_valid_out || issue_ready_in);
    assign deq_out = (load_ok && !rst_in) ? DEQ_W'(n) : '0;

    // Next-state and bundle update
    always_comb begin
        state_d  = state_q;
        valid_d  = issue_valid_out;
        count_d  = issue_count_out;
        bundle_d = issue_bundle_out;
        if (flush_in) begin
            valid_d = 1'b0;
            count_d = '0;
            state_d = RUN;
        end else if (load_ok) begin
            if (n != '0) begin
                valid_d = 1'b1;
                count_d = n;
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    bundle_d[ISSUE_IDX_W'(i)] = (CNT_W'(i) < n) ? q_head_in[Q_IDX_W'(i)] : '0;
                end
                if (ser0) begin
                    state_d = SERIAL_WAIT;
                end
            end else begin
                valid_d = 1'b0;
                count_d = '0;
            end
        end else begin
            if (issue_valid_out && issue_ready_in) begin
                valid_d = 1'b0;
                count_d = '0;
            end
            if ((state_q == SERIAL_WAIT) && !issue_valid_out && rob_empty_in) begin
                state_d = RUN;
            end
        end
    end

    // State and bundle registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q          <= RUN;
            issue_valid_out  <= 1'b0;
            issue_count_out  <= '0;
            issue_bundle_out <= '0;
        end else begin
            state_q          <= state_d;
            issue_valid_out  <= valid_d;
            issue_count_out  <= count_d;
            issue_bundle_out <= bundle_d;
        end
    end

endmodule

// File: doc/instr_queue_dispatcher.md
# instr_queue_dispatcher

Consumer end of the instruction queue. Each cycle it reads the queue's head window and occupancy, decides how many uops are safe to pop, drives the queue's dequeue count, and registers them into one issue bundle for rename. It also enforces serializing-uop ordering and flush recovery. It sits between the instruction queue and the rename/ROB stage.

## Interface
Parameters:
- Q_DEPTH, default uop_pkg::INSTR_Q_DEPTH: queue depth.
- Q_WIDTH, default uop_pkg::INSTR_Q_WIDTH: width of the queue head window and dequeue count.
- ISSUE_WIDTH, default uop_pkg::ISSUE_WIDTH: maximum uops per bundle. Must satisfy 1 ≤ ISSUE_WIDTH ≤ Q_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- clk_in  in  1  clock.
- rst_in  in  1  async active-high reset.
- flush_in  in  1  pipeline flush (synchronous).
- q_head_in  in  instr_queue_t  head window; entry i is the i-th oldest uop.
- q_size_in  in  $clog2(Q_DEPTH)  queue occupancy.
- q_full_in  in  1  queue full. Effective occupancy is Q_DEPTH when set.
- q_empty_in  in  1  queue empty.
- deq_out  out  $clog2(Q_WIDTH+1)  uops popped this cycle. Combinational.
- issue_valid_out  out  1  bundle valid.
- issue_count_out  out  $clog2(ISSUE_WIDTH+1)  live slots in the bundle, 1..ISSUE_WIDTH when valid.
- issue_bundle_out  out  dispatch_bundle_t  registered uops. Slot 0 is the oldest.
- issue_ready_in  in  1  downstream accepts the whole bundle this cycle.
- rob_empty_in  in  1  ROB holds no uops.

## Operation
- avail = q_full_in ? Q_DEPTH : (q_empty_in ? 0 : q_size_in).
- load_ok = !flush_in && state==RUN && (!issue_valid_out || issue_ready_in).
- n = min(avail, ISSUE_WIDTH), then truncated at serializing uops:
  - If slot 0 has the serialize bit set, n = 1.
  - Otherwise n = the index of the first serializing slot below n, if there is one.
- deq_out = load_ok ? n : 0. This equals the number of uops loaded into the bundle at the same edge.
- If load_ok and n > 0, the bundle register captures slots 0..n-1. Unused slots are zeroed. issue_valid_out is set and issue_count_out = n.
- If load_ok and n == 0 and the old bundle was accepted, issue_valid_out is cleared.
- If a bundle is valid and issue_ready_in is low, the bundle holds stable.

State machine (dispatch_state_e):
- RUN:
  - Normal loading.
  - Loading a bundle whose slot 0 is serializing moves the FSM to SERIAL_WAIT.
- SERIAL_WAIT:
  - No loads are made and deq_out = 0.
  - Returns to RUN when the bundle has been accepted (issue_valid_out low) and rob_empty_in is high.
- Flush, in any state:
  - deq_out = 0 during the flush cycle.
  - At the next edge: issue_valid_out = 0, issue_count_out = 0, state = RUN.
  - Flush wins over a simultaneous accept or load.

Reset values:
- issue_valid_out = 0, issue_count_out = 0, issue_bundle_out = '0, state = RUN.
- deq_out is forced to 0 while rst_in is high.

## Timing
- Latency: a uop visible in q_head_in slot k at cycle t appears in issue_bundle_out at t+1, provided it is dispatched at t.
- Throughput: one bundle per cycle when issue_ready_in stays high.
- Back-to-back is allowed: an accept and a new load happen at the same edge with no bubble.
- deq_out must be stable before the edge. The queue advances its head at the same edge the bundle loads.
- Reset:
  - Asserting rst_in clears all state immediately, without waiting for a clock edge.
  - Deassertion takes effect at the next edge; the first load can occur in that cycle.
- A serializing uop adds a minimum of 2 cycles: the bundle is accepted, then rob_empty_in is sampled high, then the next load happens.

## Structure
- uop_pkg additions:
  - ISSUE_WIDTH.
  - Serialize bit in the uop struct.
  - dispatch_bundle_t: array [ISSUE_WIDTH] of the uop struct.
  - dispatch_state_e {RUN, SERIAL_WAIT}.
- One combinational sub-module, dispatch_count_calc. It takes the head window and avail, and returns n (min plus serialize truncation) and the serialize-at-slot-0 flag.
- The FSM and bundle register live in the top module.

## Test plan
All scenarios use Q_DEPTH=16, Q_WIDTH=4, ISSUE_WIDTH=4.
- Reset mid-operation: assert rst_in while a bundle is valid → issue_valid_out=0 and deq_out=0 with no clock edge; first load on the edge after deassertion.
- Partial occupancy: q_size_in=3, ready high → deq_out=3; next cycle issue_count_out=3 and slot 3=0.
- Full queue: q_full_in=1, q_size_in=0 (wrapped value) → deq_out=4, not 0.
- Backpressure: ready low for 3 cycles → bundle stable, deq_out=0 for all 3; ready high → accept and new load at the same edge.
- Serialize: slot 2 serializing → deq_out=2. Next load has serializing uop at slot 0 → deq_out=1, FSM enters SERIAL_WAIT. Hold rob_empty_in=0 for 5 cycles → deq_out=0; raise it → RUN and loading resumes.
- Flush with simultaneous ready and nonempty queue → deq_out=0, issue_valid_out=0 next cycle, FSM enters RUN even from SERIAL_WAIT.
